alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, number of execute cycles for multiply (legal 1..15).
REQ-002 SHALL have parameter DIV_CYCLES, default 8, number of execute cycles for divide (legal 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port clr  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  requester presents an operation.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept; high only in IDLE.
REQ-007 SHALL have port req_op  input  4  opcode; 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not; 12-15 illegal.
REQ-008 SHALL have ports req_a, req_b  input  32 each  operands.
REQ-009 SHALL have ports alu_a, alu_b  output  32 each  registered operands to the ALU.
REQ-010 SHALL have port alu_control  output  12  one-hot ALU select; bit index equals opcode.
REQ-011 SHALL have ports alu_zhi, alu_zlo  input  32 each  ALU result halves.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-014 SHALL have ports rsp_hi, rsp_lo  output  32 each  captured result.
REQ-015 SHALL have port rsp_err  output  1  illegal opcode (or divide-by-zero, see REQ-029).
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, EXEC, RESP.
REQ-018 SHALL accept a request in IDLE when req_valid && req_ready (cycle T), registering req_a/req_b into alu_a/alu_b and the opcode.
REQ-019 SHALL, for legal opcodes, enter EXEC at T+1 with a down-counter loaded to L-1, where L = MUL_CYCLES for mul, DIV_CYCLES for div, 1 otherwise.
REQ-020 SHALL drive alu_control one-hot (bit = opcode) and hold alu_a/alu_b constant on every EXEC cycle; alu_control SHALL be all-zero outside EXEC.
REQ-021 SHALL capture alu_zhi/alu_zlo into rsp_hi/rsp_lo at the edge ending the EXEC cycle where the counter is 0, and enter RESP; rsp_valid high from T+L+1.
REQ-022 SHALL, for illegal opcodes, skip EXEC: go IDLE -> RESP at T+1 with rsp_hi=rsp_lo=0, rsp_err=1, alu_control never asserted.
REQ-023 SHALL hold rsp_valid, rsp_hi, rsp_lo, rsp_err stable in RESP until rsp_ready is high; on that edge return to IDLE and clear rsp_valid.
REQ-024 SHALL keep req_ready low in EXEC and RESP; a request presented then is not accepted and has no effect.
REQ-025 SHALL leave rsp_hi/rsp_lo/rsp_err at their last values in IDLE (only rsp_valid qualifies them).

Reset
REQ-026 SHALL on clr at any edge, including mid-EXEC or RESP, enter IDLE next cycle and discard the in-flight operation.
REQ-027 SHALL reset: req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_hi=rsp_lo=0, alu_a=alu_b=0, alu_control=0, counter=0.
REQ-028 SHALL give clr priority over every handshake in the same cycle.

Configuration
REQ-029 SHALL, with macro ALU_SEQ_DIVZERO_CHECK_EN defined, treat div with req_b==0 as REQ-022 (no EXEC, rsp 0/0, rsp_err=1); without it, such a divide SHALL execute normally for DIV_CYCLES and rsp_err SHALL be 0 for it.

Structure
REQ-030 SHALL take opcode encodings, the op-to-control-bit mapping and state encodings from the shared ALU definitions package/header, also used by the ALU decode path.
REQ-031 SHALL have one natural sub-module, alu_op_decode: combinational opcode -> {one-hot control, latency, illegal} lookup.

Verification
REQ-032 add: A=5, B=7 accepted at T -> alu_control=12'h001 at T+1 only; rsp_valid at T+2, rsp_lo=12, rsp_hi=0, rsp_err=0.
REQ-033 mul, MUL_CYCLES=4: A=32'h0001_0000, B=32'h0001_0000 -> alu_control=12'h004 T+1..T+4; rsp at T+5 hi=1, lo=0.
REQ-034 div 17/5 with rsp_ready held low 3 cycles -> rsp hi=2, lo=3 held stable, req_ready low, new req_valid ignored until handshake.
REQ-035 req_op=13 -> rsp_valid at T+1, rsp_err=1, 0/0, alu_control never nonzero; div 9/0 -> err=1 with macro, err=0 after 8 EXEC cycles without.
REQ-036 clr asserted at T+2 of a mul -> IDLE at T+3, all outputs per REQ-027, next request processes correctly.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared ALU definitions: opcode encodings, op-to-control-bit mapping and sequencer state encoding.
// Used by alu_op_decode and alu_op_sequencer.
package alu_op_sequencer_pkg;

    localparam int NUM_OPS   = 12;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3,
        OP_SHR = 4'd4,
        OP_SHL = 4'd5,
        OP_ROR = 4'd6,
        OP_ROL = 4'd7,
        OP_AND = 4'd8,
        OP_OR  = 4'd9,
        OP_NEG = 4'd10,
        OP_NOT = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Control bit index equals the opcode; opcodes 12-15 map to no bit at all.
    function automatic logic [NUM_OPS-1:0] op_to_ctrl(input logic [3:0] op);
        logic [NUM_OPS-1:0] c;
        c = '0;
        if (op < 4'(NUM_OPS)) begin
            c[op] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// alu_op_decode: combinational opcode -> {one-hot control, latency-1, illegal}.
// With ALU_SEQ_DIVZERO_CHECK_EN defined, a divide by zero decodes as illegal.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic [3:0]          op_i,
    input  logic [DATA_W-1:0]   b_i,
    output logic [NUM_OPS-1:0]  ctrl_o,
    output logic [CNT_W-1:0]    lat_m1_o,
    output logic                illegal_o
);

    always_comb begin
        ctrl_o    = op_to_ctrl(op_i);
        illegal_o = (op_i >= 4'(NUM_OPS));
        lat_m1_o  = '0;
        if (op_i == OP_MUL) begin
            lat_m1_o = CNT_W'(MUL_CYCLES - 1);
        end else if (op_i == OP_DIV) begin
            lat_m1_o = CNT_W'(DIV_CYCLES - 1);
        end
`ifdef ALU_SEQ_DIVZERO_CHECK_EN
        if (op_i == OP_DIV && b_i == '0) begin
            ctrl_o    = '0;
            lat_m1_o  = '0;
            illegal_o = 1'b1;
        end
`endif
    end

`ifndef ALU_SEQ_DIVZERO_CHECK_EN
    logic unused_b;
    assign unused_b = ^b_i;
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// IDLE -> EXEC -> RESP sequencer driving a multi-cycle ALU with one-hot control.
// Optional feature: ALU_SEQ_DIVZERO_CHECK_EN rejects divide-by-zero as an error response.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic                clk,
    input  logic                clr,
    // Handshake: a transfer happens on any rising edge where valid && ready; clr overrides it.
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [NUM_OPS-1:0]  alu_control,
    input  logic [DATA_W-1:0]   alu_zhi,
    input  logic [DATA_W-1:0]   alu_zlo,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_hi,
    output logic [DATA_W-1:0]   rsp_lo,
    output logic                rsp_err,
    output logic                busy,
    output state_e              dbg_state
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [NUM_OPS-1:0]   ctrl_q, ctrl_d;
    logic                 err_q, err_d;

    logic [NUM_OPS-1:0]   dec_ctrl;
    logic [CNT_W-1:0]     dec_lat_m1;
    logic                 dec_illegal;

    alu_op_decode #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_decode (
        .op_i      (req_op),
        .b_i       (req_b),
        .ctrl_o    (dec_ctrl),
        .lat_m1_o  (dec_lat_m1),
        .illegal_o (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d    = req_a;
                    b_d    = req_b;
                    ctrl_d = dec_ctrl;
                    cnt_d  = dec_lat_m1;
                    // Illegal requests bypass the ALU and answer with a zeroed error response.
                    if (dec_illegal) begin
                        state_d = ST_RESP;
                        hi_d    = '0;
                        lo_d    = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    hi_d    = alu_zhi;
                    lo_d    = alu_zlo;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign alu_control = (state_q == ST_EXEC) ? ctrl_q : '0;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign rsp_hi      = hi_q;
    assign rsp_lo      = lo_q;
    assign rsp_err     = err_q;
    assign dbg_state   = state_q;

endmodule
